// File: rtl/uart_frame_tx.sv
// uart_frame_tx: sends the 8-byte frame {HEAD0, HEAD1, P0, P1, P2, P3, CTRL, TAIL},
// byte 0 first, to a byte-level UART transmitter over a send_go/tx_done handshake.
// An optional idle gap is inserted between bytes and each byte can be given a
// completion timeout. All outputs are registered.
//
// state | meaning
// IDLE  | no frame in flight; frame_req accepted here
// SEND  | one-clock send_go pulse for the byte at idx
// WAIT  | waiting for tx_done of the byte at idx; timeout timer running
// GAP   | idle clocks between a byte's tx_done and the next send_go
module uart_frame_tx #(
    parameter logic [7:0] HEAD0      = 8'h55,
    parameter logic [7:0] HEAD1      = 8'hA5,
    parameter logic [7:0] TAIL       = 8'hF0,
    parameter int         GAP_CYCLES = 0,
    parameter int         TIMEOUT    = 0
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_req,
    input  logic [31:0] payload,
    input  logic [7:0]  ctrl_in,
    input  logic        tx_done,
    output logic [7:0]  tx_data,
    output logic        send_go,
    output logic        busy,
    output logic        frame_done,
    output logic        timeout_err
);

    typedef enum logic [1:0] {IDLE, SEND, WAIT, GAP} state_t;

    // Timers count down; a byte times out when the wait timer reaches zero,
    // the gap ends when the gap timer reaches zero.
    localparam logic [15:0] GAP_LD  = 16'(GAP_CYCLES);
    localparam logic [23:0] WAIT_LD = (TIMEOUT == 0) ? 24'd0 : 24'(TIMEOUT - 1);
    localparam bit          TO_EN   = (TIMEOUT != 0);

    state_t      state, state_nxt;
    logic [2:0]  idx, idx_nxt;
    logic [31:0] pay_q, pay_nxt;
    logic [7:0]  ctrl_q, ctrl_nxt;
    logic [15:0] gap_cnt, gap_nxt;
    logic [23:0] wait_cnt, wait_nxt;
    logic [7:0]  tx_data_nxt;
    logic        send_go_nxt, busy_nxt, frame_done_nxt, timeout_err_nxt;

    function automatic logic [7:0] frame_byte(input logic [2:0]  i,
                                              input logic [31:0] p,
                                              input logic [7:0]  c);
        case (i)
            3'd0:    frame_byte = HEAD0;
            3'd1:    frame_byte = HEAD1;
            3'd2:    frame_byte = p[7:0];
            3'd3:    frame_byte = p[15:8];
            3'd4:    frame_byte = p[23:16];
            3'd5:    frame_byte = p[31:24];
            3'd6:    frame_byte = c;
            default: frame_byte = TAIL;
        endcase
    endfunction

    // Next-state and next-output decode
    always_comb begin
        state_nxt       = state;
        idx_nxt         = idx;
        pay_nxt         = pay_q;
        ctrl_nxt        = ctrl_q;
        gap_nxt         = gap_cnt;
        wait_nxt        = wait_cnt;
        tx_data_nxt     = tx_data;
        send_go_nxt     = 1'b0;
        busy_nxt        = busy;
        frame_done_nxt  = 1'b0;
        timeout_err_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (frame_req) begin
                    state_nxt   = SEND;
                    idx_nxt     = 3'd0;
                    pay_nxt     = payload;
                    ctrl_nxt    = ctrl_in;
                    tx_data_nxt = HEAD0;
                    send_go_nxt = 1'b1;
                    busy_nxt    = 1'b1;
                end
            end
            SEND: begin
                state_nxt = WAIT;
                wait_nxt  = WAIT_LD;
            end
            WAIT: begin
                // An expiring timer wins over a tx_done arriving on the same edge.
                if (TO_EN && wait_cnt == '0) begin
                    state_nxt       = IDLE;
                    busy_nxt        = 1'b0;
                    timeout_err_nxt = 1'b1;
                end else if (tx_done) begin
                    if (idx == 3'd7) begin
                        state_nxt      = IDLE;
                        busy_nxt       = 1'b0;
                        frame_done_nxt = 1'b1;
                    end else if (GAP_CYCLES == 0) begin
                        state_nxt   = SEND;
                        idx_nxt     = idx + 3'd1;
                        tx_data_nxt = frame_byte(idx + 3'd1, pay_q, ctrl_q);
                        send_go_nxt = 1'b1;
                    end else begin
                        state_nxt = GAP;
                        gap_nxt   = GAP_LD;
                    end
                end else if (wait_cnt != '0) begin
                    wait_nxt = wait_cnt - 24'd1;
                end
            end
            GAP: begin
                if (gap_cnt == '0) begin
                    state_nxt   = SEND;
                    idx_nxt     = idx + 3'd1;
                    tx_data_nxt = frame_byte(idx + 3'd1, pay_q, ctrl_q);
                    send_go_nxt = 1'b1;
                end else begin
                    gap_nxt = gap_cnt - 16'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, frame buffer, timers and registered outputs
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= IDLE;
            idx         <= 3'd0;
            pay_q       <= '0;
            ctrl_q      <= '0;
            gap_cnt     <= '0;
            wait_cnt    <= '0;
            tx_data     <= '0;
            send_go     <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            pay_q       <= pay_nxt;
            ctrl_q      <= ctrl_nxt;
            gap_cnt     <= gap_nxt;
            wait_cnt    <= wait_nxt;
            tx_data     <= tx_data_nxt;
            send_go     <= send_go_nxt;
            busy        <= busy_nxt;
            frame_done  <= frame_done_nxt;
            timeout_err <= timeout_err_nxt;
        end
    end

endmodule

// File: tb/tb_uart_frame_tx.sv
// Bench for uart_frame_tx: two instances (no gap/no timeout, and gap 5/timeout 20)
// checked every cycle against a timestamp-based frame model, plus directed
// scenarios with hand-computed expectations and a randomized phase.
module tb_uart_frame_tx;
    localparam int GAP1 = 5;
    localparam int TO1  = 20;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] payload;
    logic [7:0]  ctrl_in;
    logic        frame_req   [2];
    logic        resp_done   [2];
    logic        noise_done  [2];
    logic        tx_done     [2];
    logic [7:0]  tx_data     [2];
    logic        send_go     [2];
    logic        busy        [2];
    logic        frame_done  [2];
    logic        timeout_err [2];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    // responder controls
    int resp_dly  [2];
    int resp_left [2];
    bit resp_rand [2];

    // observation counters
    int go_cnt [2];
    int fd_cnt [2];
    int go_edge_last [2];
    int last_done_edge [2];
    logic [7:0] seen_q0 [$];
    int gap_meas [$];
    bit meas_gap = 1'b0;

    // model
    bit         m_busy  [2];
    int         m_idx   [2];
    logic [7:0] m_bytes [2][8];
    int         go_at   [2];
    int         next_go [2];
    logic [7:0] e_tx    [2];
    bit         e_go    [2];
    bit         e_done  [2];
    bit         e_to    [2];

    assign tx_done[0] = resp_done[0] | noise_done[0];
    assign tx_done[1] = resp_done[1] | noise_done[1];

    always #5 Clk = ~Clk;

    uart_frame_tx #(.GAP_CYCLES(0), .TIMEOUT(0)) dut0 (
        .Clk(Clk), .Reset(Reset), .frame_req(frame_req[0]), .payload(payload),
        .ctrl_in(ctrl_in), .tx_done(tx_done[0]), .tx_data(tx_data[0]),
        .send_go(send_go[0]), .busy(busy[0]), .frame_done(frame_done[0]),
        .timeout_err(timeout_err[0]));

    uart_frame_tx #(.GAP_CYCLES(GAP1), .TIMEOUT(TO1)) dut1 (
        .Clk(Clk), .Reset(Reset), .frame_req(frame_req[1]), .payload(payload),
        .ctrl_in(ctrl_in), .tx_done(tx_done[1]), .tx_data(tx_data[1]),
        .send_go(send_go[1]), .busy(busy[1]), .frame_done(frame_done[1]),
        .timeout_err(timeout_err[1]));

    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    task automatic check(input string nm, input int k, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %0h, want %0h", nm, k, act, exp);
        end
    endtask

    // Frame model: a frame is 8 bytes; each byte's send_go is stamped with its
    // edge number, and tx_done is honoured only on the edges after the send
    // cycle. The next byte goes out on the tx_done edge (no gap) or gap+1 edges
    // later; the byte is abandoned when TIMEOUT wait edges pass without tx_done.
    task automatic model_step(input int k, input int n);
        int g;
        int t;
        int j;
        g = (k == 1) ? GAP1 : 0;
        t = (k == 1) ? TO1 : 0;
        e_go[k]   = 1'b0;
        e_done[k] = 1'b0;
        e_to[k]   = 1'b0;
        if (Reset) begin
            m_busy[k]  = 1'b0;
            m_idx[k]   = 0;
            e_tx[k]    = 8'h00;
            next_go[k] = -1;
        end else if (!m_busy[k]) begin
            if (frame_req[k]) begin
                m_bytes[k][0] = 8'h55;
                m_bytes[k][1] = 8'hA5;
                m_bytes[k][2] = payload[7:0];
                m_bytes[k][3] = payload[15:8];
                m_bytes[k][4] = payload[23:16];
                m_bytes[k][5] = payload[31:24];
                m_bytes[k][6] = ctrl_in;
                m_bytes[k][7] = 8'hF0;
                m_busy[k]  = 1'b1;
                m_idx[k]   = 0;
                e_tx[k]    = m_bytes[k][0];
                e_go[k]    = 1'b1;
                go_at[k]   = n;
                next_go[k] = -1;
            end
        end else if (next_go[k] >= 0) begin
            if (n == next_go[k]) begin
                m_idx[k]   = m_idx[k] + 1;
                e_tx[k]    = m_bytes[k][m_idx[k]];
                e_go[k]    = 1'b1;
                go_at[k]   = n;
                next_go[k] = -1;
            end
        end else if (n > go_at[k] + 1) begin
            j = n - go_at[k] - 1;
            if (t != 0 && j == t) begin
                m_busy[k] = 1'b0;
                e_to[k]   = 1'b1;
            end else if (tx_done[k]) begin
                if (m_idx[k] == 7) begin
                    m_busy[k] = 1'b0;
                    e_done[k] = 1'b1;
                end else if (g == 0) begin
                    m_idx[k] = m_idx[k] + 1;
                    e_tx[k]  = m_bytes[k][m_idx[k]];
                    e_go[k]  = 1'b1;
                    go_at[k] = n;
                end else begin
                    next_go[k] = n + g + 1;
                end
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_busy[k] = 1'b0; m_idx[k] = 0; go_at[k] = 0; next_go[k] = -1;
            e_tx[k] = 8'h00; e_go[k] = 1'b0; e_done[k] = 1'b0; e_to[k] = 1'b0;
        end
        forever begin
            @(posedge Clk);
            cyc++;
            model_step(0, cyc);
            model_step(1, cyc);
        end
    end

    // Per-cycle compare against the model, then event bookkeeping.
    initial begin
        for (int k = 0; k < 2; k++) begin
            go_cnt[k] = 0; fd_cnt[k] = 0; go_edge_last[k] = 0; last_done_edge[k] = -1;
        end
        forever begin
            @(negedge Clk);
            if (chk_en) begin
                for (int k = 0; k < 2; k++) begin
                    check("tx_data", k, 32'(tx_data[k]), 32'(e_tx[k]));
                    check("send_go", k, 32'(send_go[k]), 32'(e_go[k]));
                    check("busy", k, 32'(busy[k]), 32'(m_busy[k]));
                    check("frame_done", k, 32'(frame_done[k]), 32'(e_done[k]));
                    check("timeout_err", k, 32'(timeout_err[k]), 32'(e_to[k]));
                end
            end
            for (int k = 0; k < 2; k++) begin
                if (send_go[k] === 1'b1) begin
                    go_cnt[k]++;
                    if (k == 0) seen_q0.push_back(tx_data[0]);
                    if (k == 1 && meas_gap && last_done_edge[1] >= 0)
                        gap_meas.push_back(cyc - last_done_edge[1]);
                    go_edge_last[k] = cyc;
                end
                if (frame_done[k] === 1'b1) fd_cnt[k]++;
                if (tx_done[k] === 1'b1) last_done_edge[k] = cyc + 1;
            end
        end
    end

    // Byte transmitter stand-in: answers each send_go with a tx_done pulse
    // resp_dly clocks later (random when resp_rand), for resp_left bytes.
    task automatic responder(input int k);
        int d;
        resp_done[k] = 1'b0;
        tick();
        forever begin
            if (send_go[k] === 1'b1 && resp_left[k] != 0) begin
                d = resp_rand[k] ? int'($urandom_range(24, 2)) : resp_dly[k];
                repeat (d - 1) tick();
                resp_done[k] = 1'b1;
                tick();
                resp_done[k] = 1'b0;
                if (resp_left[k] > 0) resp_left[k]--;
            end else begin
                tick();
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            resp_dly[k] = 10; resp_left[k] = -1; resp_rand[k] = 1'b0;
        end
        fork
            responder(0);
            responder(1);
        join_none
    end

    initial begin
        logic [7:0] exp1 [8];
        int base0;
        int base1;
        int fd0;
        int fd1;
        exp1 = '{8'h55, 8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h3C, 8'hF0};
        Reset   = 1'b1;
        payload = '0;
        ctrl_in = '0;
        for (int k = 0; k < 2; k++) begin
            frame_req[k] = 1'b0; noise_done[k] = 1'b0;
        end
        repeat (3) tick();
        chk_en = 1'b1;
        for (int k = 0; k < 2; k++) begin
            check("rst_tx_data", k, 32'(tx_data[k]), 32'h00);
            check("rst_busy", k, 32'(busy[k]), 32'h0);
            check("rst_send_go", k, 32'(send_go[k]), 32'h0);
        end
        Reset = 1'b0;
        tick();

        // 1: basic frame, no gap
        payload = 32'h44332211;
        ctrl_in = 8'h3C;
        seen_q0.delete();
        base0 = go_cnt[0]; fd0 = fd_cnt[0];
        frame_req[0] = 1'b1; tick(); frame_req[0] = 1'b0;
        payload = 32'hDEADBEEF; ctrl_in = 8'h99;
        for (int i = 0; i < 300 && fd_cnt[0] == fd0; i++) tick();
        check("t1_frame_done", 0, 32'(fd_cnt[0] - fd0), 32'd1);
        check("t1_send_go_count", 0, 32'(go_cnt[0] - base0), 32'd8);
        check("t1_byte_count", 0, 32'(seen_q0.size()), 32'd8);
        for (int i = 0; i < 8; i++)
            if (i < seen_q0.size())
                check("t1_byte", 0, 32'(seen_q0[i]), 32'(exp1[i]));
        tick();

        // 2: gap of 5 clocks on dut1
        resp_dly[1] = 4;
        last_done_edge[1] = -1;
        gap_meas.delete();
        meas_gap = 1'b1;
        fd1 = fd_cnt[1];
        frame_req[1] = 1'b1; tick(); frame_req[1] = 1'b0;
        for (int i = 0; i < 400 && fd_cnt[1] == fd1; i++) tick();
        meas_gap = 1'b0;
        check("t2_frame_done", 1, 32'(fd_cnt[1] - fd1), 32'd1);
        check("t2_gap_count", 1, 32'(gap_meas.size()), 32'd7);
        foreach (gap_meas[i]) check("t2_done_to_go", 1, 32'(gap_meas[i]), 32'd6);
        tick();

        // 3: mid-frame request ignored, held request gives back-to-back frame
        payload = 32'h0A0B0C0D; ctrl_in = 8'h5A;
        base0 = go_cnt[0]; fd0 = fd_cnt[0];
        frame_req[0] = 1'b1; tick(); frame_req[0] = 1'b0;
        for (int i = 0; i < 300 && go_cnt[0] - base0 < 4; i++) tick();
        frame_req[0] = 1'b1; tick(); frame_req[0] = 1'b0;
        for (int i = 0; i < 300 && go_cnt[0] - base0 < 8; i++) tick();
        frame_req[0] = 1'b1;
        for (int i = 0; i < 300 && frame_done[0] !== 1'b1; i++) tick();
        check("t3_one_frame_sends", 0, 32'(go_cnt[0] - base0), 32'd8);
        check("t3_busy_at_done", 0, 32'(busy[0]), 32'h0);
        tick();
        frame_req[0] = 1'b0;
        check("t3_b2b_send_go", 0, 32'(send_go[0]), 32'h1);
        check("t3_b2b_tx_data", 0, 32'(tx_data[0]), 32'h55);
        check("t3_b2b_busy", 0, 32'(busy[0]), 32'h1);
        for (int i = 0; i < 300 && fd_cnt[0] - fd0 < 2; i++) tick();
        check("t3_two_frames", 0, 32'(fd_cnt[0] - fd0), 32'd2);
        tick();

        // 4: timeout after byte 2 on dut1
        resp_left[1] = 3;
        base1 = go_cnt[1]; fd1 = fd_cnt[1];
        frame_req[1] = 1'b1; tick(); frame_req[1] = 1'b0;
        for (int i = 0; i < 500 && timeout_err[1] !== 1'b1; i++) tick();
        check("t4_timeout_seen", 1, 32'(timeout_err[1]), 32'h1);
        check("t4_timeout_latency", 1, 32'(cyc - go_edge_last[1] - 1), 32'd20);
        check("t4_bytes_sent", 1, 32'(go_cnt[1] - base1), 32'd4);
        check("t4_busy", 1, 32'(busy[1]), 32'h0);
        noise_done[1] = 1'b1; tick(); noise_done[1] = 1'b0;
        repeat (5) tick();
        check("t4_late_done_ignored", 1, 32'(go_cnt[1] - base1), 32'd4);
        check("t4_no_frame_done", 1, 32'(fd_cnt[1] - fd1), 32'd0);
        resp_left[1] = -1;

        // 5: reset while waiting on byte 4
        resp_dly[0] = 8; resp_dly[1] = 8;
        base0 = go_cnt[0];
        frame_req[0] = 1'b1; frame_req[1] = 1'b1; tick();
        frame_req[0] = 1'b0; frame_req[1] = 1'b0;
        for (int i = 0; i < 300 && go_cnt[0] - base0 < 5; i++) tick();
        repeat (2) tick();
        Reset = 1'b1; tick(); Reset = 1'b0;
        check("t5_rst_tx_data", 0, 32'(tx_data[0]), 32'h00);
        check("t5_rst_busy", 0, 32'(busy[0]), 32'h0);
        check("t5_rst_send_go", 0, 32'(send_go[0]), 32'h0);
        repeat (12) tick();
        frame_req[0] = 1'b1; tick(); frame_req[0] = 1'b0;
        check("t5_restart_tx_data", 0, 32'(tx_data[0]), 32'h55);
        check("t5_restart_send_go", 0, 32'(send_go[0]), 32'h1);
        for (int i = 0; i < 300 && busy[0] === 1'b1; i++) tick();
        repeat (30) tick();

        // 6: spurious tx_done in IDLE and in the SEND cycle
        resp_dly[0] = 10;
        noise_done[0] = 1'b1; tick(); noise_done[0] = 1'b0; tick();
        check("t6_idle_busy", 0, 32'(busy[0]), 32'h0);
        base0 = go_cnt[0]; fd0 = fd_cnt[0];
        frame_req[0] = 1'b1; tick(); frame_req[0] = 1'b0;
        noise_done[0] = 1'b1; tick(); noise_done[0] = 1'b0;
        check("t6_send_done_ignored", 0, 32'(send_go[0]), 32'h0);
        for (int i = 0; i < 300 && fd_cnt[0] == fd0; i++) tick();
        check("t6_send_go_count", 0, 32'(go_cnt[0] - base0), 32'd8);

        // randomized traffic
        resp_rand[0] = 1'b1; resp_rand[1] = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            payload = $urandom;
            ctrl_in = 8'($urandom);
            for (int k = 0; k < 2; k++) begin
                frame_req[k]  = ($urandom_range(7, 0) == 0);
                noise_done[k] = ($urandom_range(39, 0) == 0);
            end
            Reset = ($urandom_range(599, 0) == 0);
            tick();
        end
        Reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            frame_req[k] = 1'b0; noise_done[k] = 1'b0;
        end
        repeat (60) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
